// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode constants, ALU operation codes, the control
// sequencer step encoding, and helpers that classify an opcode and map it to
// the ALU operation it needs. Imported by the control sequencer, the datapath
// and the benches.
package cpu_defs;

  // Instruction opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes; 7 is reserved and never produced
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd8;
  localparam logic [3:0] ALU_ROL  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [3:0] ALU_NEG  = 4'd12;
  localparam logic [3:0] ALU_NOT  = 4'd13;

  // Sequencer steps: T0-T2 fetch, T3-T6 execute, HALTED idle
  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, T5, T6, HALTED
  } state_t;

  // Execute-sequence families
  typedef enum logic [2:0] {
    CLS_REG, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_HALT, CLS_NOP
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:     return CLS_REG;
      OP_ADDI, OP_ANDI, OP_ORI:    return CLS_IMM;
      OP_MUL, OP_DIV:              return CLS_MULDIV;
      OP_NEG, OP_NOT:              return CLS_UNARY;
      OP_HALT:                     return CLS_HALT;
      default:                     return CLS_NOP;
    endcase
  endfunction

  function automatic logic [3:0] alu_op_of(input logic [4:0] op);
    case (op)
      OP_SUB:           return ALU_SUB;
      OP_AND, OP_ANDI:  return ALU_AND;
      OP_OR,  OP_ORI:   return ALU_OR;
      OP_SHR:           return ALU_SHR;
      OP_SHRA:          return ALU_SHRA;
      OP_SHL:           return ALU_SHL;
      OP_ROR:           return ALU_ROR;
      OP_ROL:           return ALU_ROL;
      OP_MUL:           return ALU_MUL;
      OP_DIV:           return ALU_DIV;
      OP_NEG:           return ALU_NEG;
      OP_NOT:           return ALU_NOT;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decode.sv
// One-hot register strobe decoder.
//   en     : 1 to assert a strobe, 0 forces all-zero output
//   sel    : 4-bit register index
//   onehot : NREGS-wide strobe vector, at most one bit set
module reg_select_decode #(
  parameter int NREGS = 16
) (
  input  logic             en,
  input  logic [3:0]       sel,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (int'(sel) < NREGS)) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the datapath. Fetches over T0-T2, then sequences
// the execute steps for register, immediate, mul/div and unary instructions.
// All strobes are combinational in the current step and the IR fields.
//   clock, clear       : clock and synchronous active-high reset (restart at T0)
//   IR                 : instruction register contents from the datapath
//   Stop               : halt request, honoured at the instruction boundary
//   Run                : 1 while sequencing, 0 once halted
//   PCout..Cout        : single-bit datapath strobes
//   RegisterImmediate  : sign-extended IR[18:0]
//   ALUop              : ALU operation for the current step
//   Rin, Rout          : one-hot register load/drive strobes
module control_sequencer
  import cpu_defs::*;
#(
  parameter int NREGS = 16,
  parameter int ALUW  = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             Stop,
  output logic             Run,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic             Cout,
  output logic [31:0]      RegisterImmediate,
  output logic [ALUW-1:0]  ALUop,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout
);

  state_t     state, next_state;
  op_class_t  cls;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic [ALUW-1:0] alu_code;
  logic       rin_en, rout_en;
  logic [3:0] rin_sel, rout_sel;
  logic       last_step;

  assign opcode   = IR[31:27];
  assign ra       = IR[26:23];
  assign rb       = IR[22:19];
  assign rc       = IR[18:15];
  assign cls      = op_class(opcode);
  assign alu_code = ALUW'(alu_op_of(opcode));

  assign RegisterImmediate = {{13{IR[18]}}, IR[18:0]};
  assign Run = clear || (state != HALTED);

  always_ff @(posedge clock) begin
    if (clear) state <= T0;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    last_step  = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0; Zlowout = 1'b0;
    Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0; Cout = 1'b0;
    ALUop    = '0;
    rin_en   = 1'b0;
    rin_sel  = ra;
    rout_en  = 1'b0;
    rout_sel = rb;

    case (state)
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        next_state = T1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        next_state = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = T3;
      end
      T3: begin
        case (cls)
          CLS_REG, CLS_IMM: begin
            rout_en = 1'b1; rout_sel = rb; Yin = 1'b1;
            next_state = T4;
          end
          CLS_MULDIV: begin
            rout_en = 1'b1; rout_sel = ra; Yin = 1'b1;
            next_state = T4;
          end
          CLS_UNARY: begin
            rout_en = 1'b1; rout_sel = rb; ALUop = alu_code; Zlowin = 1'b1;
            next_state = T4;
          end
          CLS_HALT: next_state = HALTED;
          default:  last_step = 1'b1;   // undefined opcode: nop
        endcase
      end
      T4: begin
        case (cls)
          CLS_REG: begin
            rout_en = 1'b1; rout_sel = rc; ALUop = alu_code; Zlowin = 1'b1;
            next_state = T5;
          end
          CLS_IMM: begin
            Cout = 1'b1; ALUop = alu_code; Zlowin = 1'b1;
            next_state = T5;
          end
          CLS_MULDIV: begin
            rout_en = 1'b1; rout_sel = rb; ALUop = alu_code;
            Zlowin = 1'b1; Zhighin = 1'b1;
            next_state = T5;
          end
          CLS_UNARY: begin
            Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ra;
            last_step = 1'b1;
          end
          default: next_state = T0;
        endcase
      end
      T5: begin
        case (cls)
          CLS_REG, CLS_IMM: begin
            Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ra;
            last_step = 1'b1;
          end
          CLS_MULDIV: begin
            Zlowout = 1'b1; LOin = 1'b1;
            next_state = T6;
          end
          default: next_state = T0;
        endcase
      end
      T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        last_step = 1'b1;
      end
      HALTED: next_state = HALTED;
      default: next_state = T0;
    endcase

    // Stop only takes effect at the instruction boundary
    if (last_step) next_state = Stop ? HALTED : T0;

    // clear overrides whatever the current step decodes to
    if (clear) begin
      next_state = T0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
      Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
      Yin = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0; Zlowout = 1'b0;
      Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0; Cout = 1'b0;
      ALUop   = '0;
      rin_en  = 1'b0;
      rout_en = 1'b0;
    end
  end

  reg_select_decode #(.NREGS(NREGS)) u_rin_decode (
    .en     (rin_en),
    .sel    (rin_sel),
    .onehot (Rin)
  );

  reg_select_decode #(.NREGS(NREGS)) u_rout_decode (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR    = 32'h0;
  logic        Stop  = 1'b0;
  logic        Run;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Cout;
  logic [31:0] RegisterImmediate;
  logic [3:0]  ALUop;
  logic [15:0] Rin, Rout;

  control_sequencer #(.NREGS(16), .ALUW(4)) dut (
    .clock(clock), .clear(clear), .IR(IR), .Stop(Stop), .Run(Run),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .Cout(Cout),
    .RegisterImmediate(RegisterImmediate), .ALUop(ALUop), .Rin(Rin), .Rout(Rout)
  );

  always #5 clock = ~clock;

  // Strobe bit positions in the observation vector
  localparam int S_PCOUT = 0,  S_PCIN = 1,    S_INCPC = 2,    S_MARIN = 3;
  localparam int S_READ  = 4,  S_MDRIN = 5,   S_MDROUT = 6,   S_IRIN = 7;
  localparam int S_YIN   = 8,  S_ZLOWIN = 9,  S_ZHIGHIN = 10, S_ZLOWOUT = 11;
  localparam int S_ZHIGHOUT = 12, S_HIIN = 13, S_LOIN = 14,   S_COUT = 15;

  typedef struct packed {
    logic        run;
    logic [15:0] s;
    logic [3:0]  alu;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [31:0] imm;
  } obs_t;

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  function automatic obs_t sample();
    obs_t o;
    o.run  = Run;
    o.s    = {Cout, LOin, HIin, Zhighout, Zlowout, Zhighin, Zlowin, Yin,
              IRin, MDRout, MDRin, Read, MARin, IncPC, PCin, PCout};
    o.alu  = ALUop;
    o.rin  = Rin;
    o.rout = Rout;
    o.imm  = RegisterImmediate;
    return o;
  endfunction

  function automatic logic [15:0] bit_of(input int b);
    logic [15:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic obs_t mk(input logic [15:0] s, input logic [3:0] alu,
                              input logic [15:0] rin, input logic [15:0] rout,
                              input logic [31:0] imm);
    obs_t o;
    o.run = 1'b1; o.s = s; o.alu = alu; o.rin = rin; o.rout = rout; o.imm = imm;
    return o;
  endfunction

  // Reference model: the list of per-cycle outputs an instruction produces,
  // straight from the instruction-level description of each family.
  function automatic void build_steps(input logic [31:0] ir, output logic is_halt);
    logic [4:0]  op;
    logic [31:0] imm;
    logic [15:0] ra1, rb1, rc1;
    logic [3:0]  alu;
    int          fam; // 0 reg, 1 imm, 2 mul/div, 3 unary, 4 halt, 5 nop
    op  = ir[31:27];
    imm = {{13{ir[18]}}, ir[18:0]};
    ra1 = 16'h1 << ir[26:23];
    rb1 = 16'h1 << ir[22:19];
    rc1 = 16'h1 << ir[18:15];
    case (op)
      5'b00011: begin fam = 0; alu = 4'd0;  end
      5'b00100: begin fam = 0; alu = 4'd1;  end
      5'b00101: begin fam = 0; alu = 4'd2;  end
      5'b00110: begin fam = 0; alu = 4'd3;  end
      5'b00111: begin fam = 0; alu = 4'd8;  end
      5'b01000: begin fam = 0; alu = 4'd9;  end
      5'b01001: begin fam = 0; alu = 4'd4;  end
      5'b01010: begin fam = 0; alu = 4'd5;  end
      5'b01011: begin fam = 0; alu = 4'd6;  end
      5'b01100: begin fam = 1; alu = 4'd0;  end
      5'b01101: begin fam = 1; alu = 4'd2;  end
      5'b01110: begin fam = 1; alu = 4'd3;  end
      5'b01111: begin fam = 2; alu = 4'd10; end
      5'b10000: begin fam = 2; alu = 4'd11; end
      5'b10001: begin fam = 3; alu = 4'd12; end
      5'b10010: begin fam = 3; alu = 4'd13; end
      5'b11011: begin fam = 4; alu = 4'd0;  end
      default:  begin fam = 5; alu = 4'd0;  end
    endcase
    exp_q.delete();
    exp_q.push_back(mk(bit_of(S_PCOUT) | bit_of(S_MARIN) | bit_of(S_INCPC) | bit_of(S_ZLOWIN), 0, 0, 0, imm));
    exp_q.push_back(mk(bit_of(S_ZLOWOUT) | bit_of(S_PCIN) | bit_of(S_READ) | bit_of(S_MDRIN), 0, 0, 0, imm));
    exp_q.push_back(mk(bit_of(S_MDROUT) | bit_of(S_IRIN), 0, 0, 0, imm));
    case (fam)
      0: begin
        exp_q.push_back(mk(bit_of(S_YIN), 0, 0, rb1, imm));
        exp_q.push_back(mk(bit_of(S_ZLOWIN), alu, 0, rc1, imm));
        exp_q.push_back(mk(bit_of(S_ZLOWOUT), 0, ra1, 0, imm));
      end
      1: begin
        exp_q.push_back(mk(bit_of(S_YIN), 0, 0, rb1, imm));
        exp_q.push_back(mk(bit_of(S_COUT) | bit_of(S_ZLOWIN), alu, 0, 0, imm));
        exp_q.push_back(mk(bit_of(S_ZLOWOUT), 0, ra1, 0, imm));
      end
      2: begin
        exp_q.push_back(mk(bit_of(S_YIN), 0, 0, ra1, imm));
        exp_q.push_back(mk(bit_of(S_ZLOWIN) | bit_of(S_ZHIGHIN), alu, 0, rb1, imm));
        exp_q.push_back(mk(bit_of(S_ZLOWOUT) | bit_of(S_LOIN), 0, 0, 0, imm));
        exp_q.push_back(mk(bit_of(S_ZHIGHOUT) | bit_of(S_HIIN), 0, 0, 0, imm));
      end
      3: begin
        exp_q.push_back(mk(bit_of(S_ZLOWIN), alu, 0, rb1, imm));
        exp_q.push_back(mk(bit_of(S_ZLOWOUT), 0, ra1, 0, imm));
      end
      default: exp_q.push_back(mk(16'h0, 0, 0, 0, imm));
    endcase
    is_halt = (fam == 4);
  endfunction

  // Runs one instruction starting in T0. Stop is held high for step indices
  // stop_lo..stop_hi; clear is asserted at step abort_at (-1: never).
  task automatic run_instr(input logic [31:0] ir, input int stop_lo, input int stop_hi,
                           input int abort_at, input string name, output logic halted);
    logic is_halt;
    obs_t o, e;
    int   n;
    build_steps(ir, is_halt);
    n = exp_q.size();
    IR = ir;
    halted = is_halt || ((n - 1) >= stop_lo && (n - 1) <= stop_hi);
    for (int i = 0; i < n; i++) begin
      Stop = (i >= stop_lo && i <= stop_hi);
      if (i == abort_at) clear = 1'b1;
      @(negedge clock);
      o = sample();
      checks++;
      if (i == abort_at) begin
        e = mk(16'h0, 0, 0, 0, exp_q[i].imm);
        o.run = 1'b1;
        if (o !== e) begin
          errors++;
          $display("FAIL %s abort step %0d: got %h want %h", name, i, o, e);
        end
      end else if (o !== exp_q[i]) begin
        errors++;
        $display("FAIL %s step %0d: got %h want %h", name, i, o, exp_q[i]);
      end
      @(posedge clock); #1;
      if (i == abort_at) begin
        clear  = 1'b0;
        Stop   = 1'b0;
        halted = 1'b0;
        return;
      end
    end
    Stop = 1'b0;
  endtask

  task automatic check_halted(input int cycles, input string name);
    obs_t o, e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      o = sample();
      e = mk(16'h0, 0, 0, 0, {{13{IR[18]}}, IR[18:0]});
      e.run = 1'b0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s halted cycle %0d: got %h want %h", name, i, o, e);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic do_clear(input string name);
    obs_t o, e;
    clear = 1'b1;
    @(negedge clock);
    o = sample();
    o.run = 1'b1;
    e = mk(16'h0, 0, 0, 0, {{13{IR[18]}}, IR[18:0]});
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s clear strobes: got %h want %h", name, o, e);
    end
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    do_clear("reset");
  endtask

  task automatic test_rol();
    logic h;
    run_instr(32'h43820000, -1, -1, -1, "rol", h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL rol halted: got %b want 0", h); end
    run_instr(32'h43820000, -1, -1, -1, "rol_again", h);
  endtask

  task automatic test_addi();
    logic h;
    run_instr({5'b01100, 4'd2, 4'd3, 19'h7FFFB}, -1, -1, -1, "addi", h);
    checks++;
    if (RegisterImmediate !== 32'hFFFFFFFB) begin
      errors++;
      $display("FAIL addi imm: got %h want FFFFFFFB", RegisterImmediate);
    end
  endtask

  task automatic test_mul();
    logic h;
    run_instr(32'h79880000, -1, -1, -1, "mul", h);
    run_instr({5'b10001, 4'd9, 4'd15, 19'h0}, -1, -1, -1, "neg_after_mul", h);
  endtask

  task automatic test_halt();
    logic h;
    run_instr({5'b11011, 27'h0}, -1, -1, -1, "halt", h);
    check_halted(10, "halt");
    do_clear("halt_clear");
    run_instr(32'h43820000, -1, -1, -1, "after_halt", h);
  endtask

  task automatic test_stop();
    logic h;
    run_instr({5'b00011, 4'd1, 4'd2, 4'd3, 15'h0}, 3, 5, -1, "stop_add", h);
    check_halted(3, "stop_add");
    do_clear("stop_clear");
    run_instr({5'b00011, 4'd4, 4'd5, 4'd6, 15'h0}, 1, 1, -1, "stop_t1", h);
    run_instr({5'b00110, 4'd7, 4'd8, 4'd9, 15'h0}, -1, -1, -1, "after_stop_t1", h);
  endtask

  task automatic test_clear_abort();
    logic h;
    run_instr({5'b00100, 4'd5, 4'd6, 4'd7, 15'h0}, -1, -1, 4, "sub_abort", h);
    run_instr({5'b00101, 4'd1, 4'd2, 4'd3, 15'h0}, -1, -1, -1, "after_abort", h);
  endtask

  task automatic test_random();
    logic [4:0]  ops [19];
    logic [31:0] r, ir;
    logic        h;
    int          lo, hi;
    ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000,
            5'b10001, 5'b10010, 5'b11011, 5'b00000, 5'b11111};
    for (int k = 0; k < 150; k++) begin
      r  = $urandom();
      ir = {ops[$urandom_range(0, 18)], r[26:0]};
      if ($urandom_range(0, 3) == 0) begin
        lo = $urandom_range(0, 6);
        hi = lo + $urandom_range(0, 3);
      end else begin
        lo = -1; hi = -1;
      end
      run_instr(ir, lo, hi, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1,
                "random", h);
      if (h) begin
        check_halted(2, "random");
        do_clear("random_clear");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_rol();
    test_addi();
    test_mul();
    test_halt();
    test_stop();
    test_clear_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit directly upstream of `datapath`.
- Fetches an instruction over T0–T2, decodes IR, then sequences the execute steps for register and immediate ALU instructions.
- Drives every datapath strobe (Rin/Rout one-hots, Yin, Zlowin/Zhighin, ALUop, …) cycle by cycle and replaces hand-written testbench step tables.

Parameters:
- `NREGS`, 16, number of general registers (width of Rin/Rout).
- `ALUW`, 4, ALUop width.

Ports:
- `clock`  in  1  system clock; all state changes on posedge.
- `clear`  in  1  synchronous active-high reset.
- `IR`  in  32  instruction register contents from datapath.
- `Stop`  in  1  request halt at next instruction boundary.
- `Run`  out  1  1 while sequencing; 0 when halted.
- `PCout`, `PCin`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`  out  1 each  datapath strobes.
- `Zlowin`, `Zhighin`, `Zlowout`, `Zhighout`, `HIin`, `LOin`  out  1 each  Z/HI/LO strobes.
- `Cout`  out  1  immediate drive enable (RegisterImmediate onto bus).
- `RegisterImmediate`  out  32  sign-extended IR[18:0].
- `ALUop`  out  ALUW  ALU operation.
- `Rin`, `Rout`  out  NREGS each  one-hot register strobes.

Behaviour:
- State register updates on posedge `clock`. All outputs are combinational functions of state and IR (Moore plus IR fields), with no extra latency.
- Any strobe not listed for a state is 0.
- `clear`=1 at a posedge forces state T0 and `Run`=1, aborting any instruction mid-sequence. During clear all strobes are 0 (clear dominates state decode).
- Field decode:
  - opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
  - `RegisterImmediate` = {{13{IR[18]}}, IR[18:0]}, driven continuously.
- Fetch, identical for all instructions:
  - T0: `PCout`, `MARin`, `IncPC`, `Zlowin`.
  - T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - T2: `MDRout`, `IRin`.
- R-format two-operand ops (add, sub, and, or, shr, shra, shl, ror, rol):
  - T3: `Rout[Rb]`, `Yin`.
  - T4: `Rout[Rc]`, `ALUop`=op, `Zlowin`.
  - T5: `Zlowout`, `Rin[Ra]`.
  - Then T0.
- Immediate ops (addi, andi, ori): as R-format, except T4 asserts `Cout` instead of `Rout[Rc]`.
- mul/div:
  - T3: `Rout[Ra]`, `Yin`.
  - T4: `Rout[Rb]`, `ALUop`, `Zlowin`, `Zhighin`.
  - T5: `Zlowout`, `LOin`.
  - T6: `Zhighout`, `HIin`.
  - Then T0.
- neg/not:
  - T3: `Rout[Rb]`, `ALUop`, `Zlowin`.
  - T4: `Zlowout`, `Rin[Ra]`.
  - Then T0.
- halt: from T3 go to HALTED. Undefined opcode: T3 returns to T0 with no strobes (nop).
- HALTED: all strobes 0, `Run`=0; leaves only on `clear`.
- `Stop`:
  - Sampled only on the last execute step of an instruction. If 1, the next state is HALTED instead of T0.
  - Stop asserted in any other state has no effect until that boundary.
  - Stop and halt together give HALTED (same result).
- One-hot rule: `Rin`/`Rout` have at most one bit set in any state. A 4-bit field indexes 0..15 directly; no wrap handling is needed at `NREGS`=16.
- Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, halt 11011.
- ALUop codes: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 8, ROL 9, MUL 10, DIV 11, NEG 12, NOT 13. Code 7 is reserved and never emitted.

Decomposition:
- Shared package `cpu_defs`: opcode constants, ALUop constants, state encoding (T0–T6, HALTED).
- `datapath` and testbenches import the ALUop constants from `cpu_defs`.
- One natural sub-module: `reg_select_decode`, a 4-to-16 one-hot decoder with enable, instantiated twice (Rin, Rout).

Test Plan:
- clear 1 cycle, IR=rol R7,R0,R4 (0x43820000):
  - T0–T2 fetch strobes as specified.
  - T3 `Rout`=0x0001 with `Yin`.
  - T4 `Rout`=0x0010, `ALUop`=9, `Zlowin`.
  - T5 `Rin`=0x0080 with `Zlowout`.
  - Next cycle T0 again.
- IR=addi R2,R3,-5 (opcode 01100, C=0x7FFFB): `RegisterImmediate`=0xFFFFFFFB; T4 `Cout`=1, `Rout`=0, `ALUop`=0; T5 `Rin`=0x0004.
- IR=mul R3,R1 (0x79880000):
  - T3 `Rout`=0x0008.
  - T4 `Rout`=0x0002, `Zlowin` and `Zhighin`=1.
  - T5 `LOin`; T6 `HIin` with `Zhighout`.
  - 7-cycle instruction.
- halt: T3 → HALTED; `Run`=0 and all strobes 0 for 10 cycles; `clear` then returns to T0 with `Run`=1.
- `Stop`=1 pulsed during T3 of add, held through T5: HALTED after T5. Same `Stop` pulsed only in T1 and released: no halt.
- `clear` asserted in T4 of sub: next cycle T0, and `Rin` never asserted for the aborted instruction.
